// File: rtl/calc_pkg.sv
// Shared state encoding and datapath select derivation for the calculator sequencer.
package calc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT_X = 3'd1,
    ST_WAIT_Y = 3'd2,
    ST_WAIT_S = 3'd3,
    ST_EXEC   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } calc_state_e;

  // Operand/result selects sit just above the 2**opw opcode selects.
  function automatic int unsigned sel_x_of(input int unsigned opw);
    return 32'd1 << opw;
  endfunction

  function automatic int unsigned sel_y_of(input int unsigned opw);
    return (32'd1 << opw) + 32'd1;
  endfunction

  function automatic int unsigned sel_r_of(input int unsigned opw);
    return (32'd1 << opw) + 32'd2;
  endfunction

endpackage

// File: rtl/calc_lat_cnt.sv
// EXEC latency counter; tc flags the cycle whose increment reaches MAXLAT-1.
module calc_lat_cnt #(
  parameter int MAXLAT = 16,
  parameter int CW     = $clog2(MAXLAT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign tc = en && (cnt == CW'(MAXLAT - 2));

endmodule

// File: rtl/calc_seq_ctrl.sv
// Sequencer for a load-X / load-Y / execute calculator datapath with
// timeout, divide-by-zero error and result chaining.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int OPW    = 2,
  parameter int SELW   = 3,
  parameter int MAXLAT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_x,
  input  logic            start_y,
  input  logic            start_s,
  input  logic [OPW-1:0]  op,
  input  logic            chain,
  input  logic            dp_done,
  input  logic            div_zero,
  input  logic            abort,
  output logic            ld_x,
  output logic            clr_x,
  output logic            ld_y,
  output logic            clr_y,
  output logic            ld_r,
  output logic [SELW-1:0] s,
  output logic            dp_go,
  output logic [2:0]      state,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [SELW-1:0] SEL_X = SELW'(sel_x_of(OPW));
  localparam logic [SELW-1:0] SEL_Y = SELW'(sel_y_of(OPW));
  localparam logic [SELW-1:0] SEL_R = SELW'(sel_r_of(OPW));

  calc_state_e    st_q, st_d;
  logic [OPW-1:0] op_q;
  logic           res_valid;
  logic           op_ld, rv_set, rv_clr;
  logic           cnt_clr, cnt_en, cnt_tc;

  calc_lat_cnt #(.MAXLAT(MAXLAT)) u_lat (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q      <= ST_IDLE;
      op_q      <= '0;
      res_valid <= 1'b0;
    end else begin
      st_q <= st_d;
      if (op_ld)  op_q      <= op;
      if (rv_set) res_valid <= 1'b1;
      if (rv_clr) res_valid <= 1'b0;
    end
  end

  always_comb begin
    st_d    = st_q;
    ld_x    = 1'b0;
    clr_x   = 1'b0;
    ld_y    = 1'b0;
    clr_y   = 1'b0;
    ld_r    = 1'b0;
    s       = SEL_X;
    dp_go   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    op_ld   = 1'b0;
    rv_set  = 1'b0;
    rv_clr  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (st_q)
      ST_IDLE: begin
        clr_x = 1'b1;
        clr_y = 1'b1;
        st_d  = ST_WAIT_X;
      end
      ST_WAIT_X: begin
        if (chain && res_valid) s = SEL_R;
        if (start_x) begin
          ld_x = 1'b1;
          st_d = ST_WAIT_Y;
        end
      end
      ST_WAIT_Y: begin
        if (start_y) begin
          ld_y = 1'b1;
          s    = SEL_Y;
          st_d = ST_WAIT_S;
        end
      end
      ST_WAIT_S: begin
        if (start_s) begin
          op_ld   = 1'b1;
          s       = SELW'(op);
          dp_go   = 1'b1;
          cnt_clr = 1'b1;
          st_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        busy   = 1'b1;
        s      = SELW'(op_q);
        cnt_en = 1'b1;
        // A completion in the terminal cycle wins over the timeout.
        if (dp_done) begin
          if (div_zero) st_d = ST_ERR;
          else begin
            ld_r = 1'b1;
            st_d = ST_DONE;
          end
        end else if (cnt_tc) begin
          st_d = ST_ERR;
        end
      end
      ST_DONE: begin
        done   = 1'b1;
        rv_set = 1'b1;
        st_d   = ST_WAIT_X;
      end
      ST_ERR: begin
        err    = 1'b1;
        clr_x  = 1'b1;
        clr_y  = 1'b1;
        rv_clr = 1'b1;
      end
      default: st_d = ST_IDLE;
    endcase
    // Abort beats every strobe; status decode of the current state stays visible.
    if (abort && st_q != ST_IDLE) begin
      st_d    = ST_IDLE;
      ld_x    = 1'b0;
      ld_y    = 1'b0;
      ld_r    = 1'b0;
      dp_go   = 1'b0;
      op_ld   = 1'b0;
      cnt_clr = 1'b0;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl with default parameters.
module tb_calc_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_x = 1'b0, start_y = 1'b0, start_s = 1'b0;
  logic [1:0] op = 2'd0;
  logic       chain = 1'b0, dp_done = 1'b0, div_zero = 1'b0, abort = 1'b0;
  logic       ld_x, clr_x, ld_y, clr_y, ld_r, dp_go, busy, done, err;
  logic [2:0] s, state;
  logic [8:0] o;

  int vecs = 0;
  int miss = 0;

  // {ld_x, clr_x, ld_y, clr_y, ld_r, dp_go, busy, done, err}
  assign o = {ld_x, clr_x, ld_y, clr_y, ld_r, dp_go, busy, done, err};

  calc_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .start_x(start_x), .start_y(start_y), .start_s(start_s),
    .op(op), .chain(chain), .dp_done(dp_done), .div_zero(div_zero), .abort(abort),
    .ld_x(ld_x), .clr_x(clr_x), .ld_y(ld_y), .clr_y(clr_y), .ld_r(ld_r),
    .s(s), .dp_go(dp_go), .state(state), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task drv_idle;
    start_x = 0; start_y = 0; start_s = 0; op = 0;
    chain = 0; dp_done = 0; div_zero = 0; abort = 0;
  endtask

  task test_reset;
    drv_idle(); rst = 0; #1;
    vecs++; if (state !== 3'd0) begin miss++; $display("FAIL rst_state got %0d exp 0", state); end
    vecs++; if (o !== 9'b010100000 || s !== 3'd4)
      begin miss++; $display("FAIL rst_outs got %b s=%0d exp 010100000 s=4", o, s); end
    @(negedge clk); rst = 1;
    @(negedge clk); #1;
    vecs++; if (state !== 3'd1) begin miss++; $display("FAIL rst_release got %0d exp 1", state); end
  endtask

  task test_basic;
    start_x = 1; #1;
    vecs++; if (o !== 9'b100000000 || s !== 3'd4)
      begin miss++; $display("FAIL basic_ldx got %b s=%0d exp 100000000 s=4", o, s); end
    @(negedge clk); start_x = 0; start_y = 1; #1;
    vecs++; if (state !== 3'd2 || o !== 9'b001000000 || s !== 3'd5)
      begin miss++; $display("FAIL basic_ldy got st=%0d %b s=%0d exp st=2 001000000 s=5", state, o, s); end
    @(negedge clk); start_y = 0; start_s = 1; op = 2; #1;
    vecs++; if (state !== 3'd3 || o !== 9'b000001000 || s !== 3'd2)
      begin miss++; $display("FAIL basic_go got st=%0d %b s=%0d exp st=3 000001000 s=2", state, o, s); end
    @(negedge clk); start_s = 0; op = 0; #1;
    vecs++; if (state !== 3'd4 || o !== 9'b000000100 || s !== 3'd2)
      begin miss++; $display("FAIL basic_exec1 got st=%0d %b s=%0d exp st=4 000000100 s=2", state, o, s); end
    @(negedge clk); #1;
    vecs++; if (state !== 3'd4 || o !== 9'b000000100)
      begin miss++; $display("FAIL basic_exec2 got st=%0d %b exp st=4 000000100", state, o); end
    @(negedge clk); dp_done = 1; #1;
    vecs++; if (o !== 9'b000010100)
      begin miss++; $display("FAIL basic_ldr got %b exp 000010100", o); end
    @(negedge clk); dp_done = 0; #1;
    vecs++; if (state !== 3'd5 || o !== 9'b000000010)
      begin miss++; $display("FAIL basic_done got st=%0d %b exp st=5 000000010", state, o); end
    @(negedge clk); #1;
    vecs++; if (state !== 3'd1 || o !== 9'b000000000)
      begin miss++; $display("FAIL basic_return got st=%0d %b exp st=1 000000000", state, o); end
  endtask

  task test_chain_err;
    chain = 1; start_x = 1; #1;
    vecs++; if (s !== 3'd6 || ld_x !== 1'b1)
      begin miss++; $display("FAIL chain_selr got s=%0d ld_x=%b exp s=6 ld_x=1", s, ld_x); end
    @(negedge clk); chain = 0; start_x = 0; start_y = 1;
    @(negedge clk); start_y = 0; start_s = 1; op = 1;
    @(negedge clk); start_s = 0; op = 0; dp_done = 1; div_zero = 1; #1;
    vecs++; if (state !== 3'd4 || o !== 9'b000000100 || s !== 3'd1)
      begin miss++; $display("FAIL dz_noldr got st=%0d %b s=%0d exp st=4 000000100 s=1", state, o, s); end
    @(negedge clk); dp_done = 0; div_zero = 0; #1;
    vecs++; if (state !== 3'd6 || o !== 9'b010100001)
      begin miss++; $display("FAIL dz_err got st=%0d %b exp st=6 010100001", state, o); end
    @(negedge clk); #1;
    vecs++; if (state !== 3'd6 || err !== 1'b1)
      begin miss++; $display("FAIL dz_hold got st=%0d err=%b exp st=6 err=1", state, err); end
    abort = 1; #1;
    vecs++; if (o !== 9'b010100001)
      begin miss++; $display("FAIL abort_outs got %b exp 010100001", o); end
    @(negedge clk); abort = 0; #1;
    vecs++; if (state !== 3'd0) begin miss++; $display("FAIL abort_idle got %0d exp 0", state); end
    @(negedge clk); chain = 1; #1;
    vecs++; if (state !== 3'd1 || s !== 3'd4)
      begin miss++; $display("FAIL err_clears_rv got st=%0d s=%0d exp st=1 s=4", state, s); end
    chain = 0;
  endtask

  task test_chain_reset;
    rst = 0; #1;
    @(negedge clk); rst = 1;
    @(negedge clk); chain = 1; #1;
    vecs++; if (state !== 3'd1 || s !== 3'd4)
      begin miss++; $display("FAIL chain_after_rst got st=%0d s=%0d exp st=1 s=4", state, s); end
    chain = 0;
  endtask

  task test_timeout;
    int bad;
    bad = 0;
    start_x = 1;
    @(negedge clk); start_x = 0; start_y = 1;
    @(negedge clk); start_y = 0; start_s = 1; op = 3;
    @(negedge clk); start_s = 0; op = 0;
    for (int n = 0; n < 15; n++) begin
      #1; if (state !== 3'd4) bad++;
      @(negedge clk);
    end
    vecs++; if (bad != 0) begin miss++; $display("FAIL timeout_hold got %0d non-EXEC cycles exp 0", bad); end
    #1;
    vecs++; if (state !== 3'd6 || err !== 1'b1)
      begin miss++; $display("FAIL timeout_err got st=%0d err=%b exp st=6 err=1", state, err); end
    abort = 1;
    @(negedge clk); abort = 0;
    @(negedge clk); #1;
    vecs++; if (state !== 3'd1) begin miss++; $display("FAIL timeout_recover got %0d exp 1", state); end
  endtask

  task test_back_to_back;
    int seen;
    start_x = 1; start_y = 1; #1;
    vecs++; if (o !== 9'b100000000)
      begin miss++; $display("FAIL xy_same got %b exp 100000000", o); end
    @(negedge clk); start_x = 0; start_y = 0; #1;
    vecs++; if (state !== 3'd2 || o !== 9'b000000000)
      begin miss++; $display("FAIL y_not_queued got st=%0d %b exp st=2 000000000", state, o); end
    @(negedge clk); start_y = 1; #1;
    vecs++; if (state !== 3'd2 || ld_y !== 1'b1)
      begin miss++; $display("FAIL y_fresh got st=%0d ld_y=%b exp st=2 ld_y=1", state, ld_y); end
    @(negedge clk); start_y = 0; dp_done = 1; #1;
    vecs++; if (state !== 3'd3 || o !== 9'b000000000)
      begin miss++; $display("FAIL dpdone_ignored got st=%0d %b exp st=3 000000000", state, o); end
    @(negedge clk); dp_done = 0; start_s = 1; abort = 1; #1;
    vecs++; if (state !== 3'd3 || dp_go !== 1'b0)
      begin miss++; $display("FAIL abort_prio got st=%0d dp_go=%b exp st=3 dp_go=0", state, dp_go); end
    @(negedge clk); start_s = 0; abort = 0; #1;
    vecs++; if (state !== 3'd0) begin miss++; $display("FAIL abort_ws got %0d exp 0", state); end
    @(negedge clk); start_x = 1;
    @(negedge clk); start_x = 0; start_y = 1;
    @(negedge clk); start_y = 0; start_s = 1; op = 2;
    @(negedge clk); start_s = 0; op = 0; #1;
    vecs++; if (state !== 3'd4) begin miss++; $display("FAIL rst_exec_entry got %0d exp 4", state); end
    rst = 0; #1;
    vecs++; if (state !== 3'd0 || o !== 9'b010100000 || s !== 3'd4)
      begin miss++; $display("FAIL rst_mid_exec got st=%0d %b s=%0d exp st=0 010100000 s=4", state, o, s); end
    seen = 0;
    @(negedge clk); rst = 1;
    for (int n = 0; n < 4; n++) begin
      #1; if (done === 1'b1 || err === 1'b1 || ld_r === 1'b1) seen++;
      @(negedge clk);
    end
    vecs++; if (seen != 0) begin miss++; $display("FAIL rst_no_pulse got %0d pulses exp 0", seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_chain_err();
    test_chain_reset();
    test_timeout();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl.md
CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

Interface
REQ-001 SHALL have parameter OPW, default 2, opcode width (number of ALU ops = 2**OPW).
REQ-002 SHALL have parameter SELW, default 3, datapath select width; legal only if 2**OPW+3 <= 2**SELW.
REQ-003 SHALL have parameter MAXLAT, default 16, max EXEC cycles before timeout, range 2..255.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk input 1 (rising-edge clock); rst input 1 (asynchronous, active-low reset).
REQ-005 Inputs:
- start_x, start_y, start_s  input  1 each  operand-X / operand-Y / operation strobes
- op      input  OPW  operation code
- chain   input  1    load X from result register instead of input bus
- dp_done input  1    datapath result valid
- div_zero input 1    datapath divide-by-zero flag, qualified by dp_done
- abort   input  1    synchronous return to IDLE
REQ-006 Outputs:
- ld_x, clr_x, ld_y, clr_y, ld_r  output  1 each  register load/clear strobes (ld_r = result register)
- s      output  SELW  datapath mux/op select
- dp_go  output  1     one-cycle datapath start pulse
- state  output  3     current state encoding
- busy, done, err  output  1 each  status

Function
REQ-007 States, 3-bit encoded: IDLE=0, WAIT_X=1, WAIT_Y=2, WAIT_S=3, EXEC=4, DONE=5, ERR=6; state output SHALL equal the registered state.
REQ-008 Select constants: SEL_X=2**OPW, SEL_Y=2**OPW+1, SEL_R=2**OPW+2; opcode selects = op zero-extended to SELW.
REQ-009 IDLE: clr_x=clr_y=1, s=SEL_X; next WAIT_X unconditionally.
REQ-010 WAIT_X: on start_x, ld_x=1 in the same cycle (Mealy), next WAIT_Y; s=SEL_R if chain=1 and res_valid=1, else s=SEL_X; without start_x, stay.
REQ-011 WAIT_Y: on start_y, ld_y=1, s=SEL_Y, next WAIT_S; else stay.
REQ-012 WAIT_S: on start_s, op_q<=op, s=op, dp_go=1 for exactly that cycle, latency counter cleared, next EXEC; else stay.
REQ-013 EXEC: busy=1, s=op_q; counter increments each cycle.
- dp_done=1 and div_zero=0: ld_r=1, next DONE.
- dp_done=1 and div_zero=1: next ERR.
- counter reaching MAXLAT-1 with dp_done=0: next ERR (timeout).
REQ-014 DONE: done=1 for exactly one cycle; res_valid<=1; next WAIT_X.
REQ-015 ERR: err=1 and clr_x=clr_y=1 every cycle; res_valid<=0; held until abort=1.
REQ-016 abort=1 in any state other than IDLE SHALL force next state IDLE and SHALL take priority over all other inputs; no ld_* or dp_go is asserted in that cycle.
REQ-017 Only the strobe belonging to the current state is consumed; strobes arriving in other states are ignored, not queued.
REQ-018 dp_done outside EXEC SHALL be ignored.
REQ-019 All outputs not driven by REQ-009..015 SHALL be 0, with s=SEL_X.

Reset
REQ-020 rst=0 SHALL immediately force state=IDLE, op_q=0, counter=0, res_valid=0; outputs then decode IDLE (clr_x=clr_y=1, s=SEL_X, all others 0).
REQ-021 Reset asserted mid-EXEC SHALL abandon the operation with no ld_r, done or err pulse.

Structure
REQ-022 State encoding and the SEL_X/SEL_Y/SEL_R derivation SHALL live in shared package calc_pkg.
REQ-023 The EXEC latency/timeout counter SHALL be sub-module calc_lat_cnt, with clear, enable and terminal-count output, sized $clog2(MAXLAT).

Verification
REQ-024 Reset release, then start_x, start_y, start_s with op=2 in consecutive waits; dp_done 3 cycles after dp_go -> ld_x, ld_y, dp_go with s=2, ld_r, then done pulse of 1 cycle; state returns to 1.
REQ-025 Second operation with chain=1 after REQ-024 -> ld_x with s=6 (SEL_R); with chain=1 straight after reset -> s=4.
REQ-026 dp_done=1 with div_zero=1 in EXEC -> state=6, err=1 held, no ld_r; abort -> IDLE next cycle, then WAIT_X.
REQ-027 Default MAXLAT=16, dp_done never asserted -> state=6 exactly 15 cycles after entering EXEC.
REQ-028 Same-cycle start_x+start_y in WAIT_X -> only ld_x; WAIT_Y then waits for a fresh start_y. rst=0 in EXEC -> IDLE immediately, no done or err pulse.
